// File: rtl/neuron_mac_engine_if.sv
// Beat-in / result-out handshake bundle for neuron_mac_engine.
// master = beat producer and result consumer, slave = the engine.
interface neuron_mac_engine_if #(
  parameter int N_LANES = 4,
  parameter int W_W     = 4,
  parameter int IN_W    = 4,
  parameter int BIAS_W  = 8,
  parameter int OUT_W   = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    first;
  logic                    last;
  logic [N_LANES*W_W-1:0]  weights;
  logic [N_LANES*IN_W-1:0] inputs;
  logic [BIAS_W-1:0]       bias;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_W-1:0]        out_data;
  logic                    out_sat;

  modport master (
    output in_valid, first, last, weights, inputs, bias, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, first, last, weights, inputs, bias, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/neuron_mac_engine.sv
// Neuron engine: lane MAC, saturating group accumulator, bias, activation, valid/ready result.
// Define NEURON_SIGMOID_EN for the hard-sigmoid activation; otherwise saturating ReLU.
module neuron_mac_engine #(
  parameter int N_LANES = 4,
  parameter int W_W     = 4,
  parameter int IN_W    = 4,
  parameter int BIAS_W  = 8,
  parameter int ACC_W   = 16,
  parameter int OUT_W   = 4,
  parameter int FRAC    = 2
) (
  input logic               clk,
  input logic               n_rst,
  neuron_mac_engine_if.slave bus
);
  localparam int PROD_W = W_W + IN_W + 1;
  localparam int SUM_W  = PROD_W + $clog2(N_LANES);
  // Extended width holds acc+sum, acc+bias and the activation offset without wrapping.
  localparam int EXT_W  = ((ACC_W > BIAS_W) ? ACC_W : BIAS_W) + 2;

  localparam logic signed [EXT_W-1:0] ACC_MAX = EXT_W'((2 ** (ACC_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] ACC_MIN = EXT_W'(-(2 ** (ACC_W - 1)));
  localparam logic signed [EXT_W-1:0] OUT_MAX = EXT_W'((2 ** OUT_W) - 1);
`ifdef NEURON_SIGMOID_EN
  localparam logic signed [EXT_W-1:0] ACT_OFFSET = EXT_W'(2 ** (OUT_W - 1));
`else
  localparam logic signed [EXT_W-1:0] ACT_OFFSET = '0;
`endif

  typedef enum logic [1:0] {S_ACC, S_DRAIN, S_OUT} state_t;

  state_t                    r_state;
  logic                      r_in_ready;
  logic                      r_out_valid;
  logic [OUT_W-1:0]          r_out_data;
  logic                      r_out_sat;
  logic                      r_res_done;

  logic                      r_s1_valid;
  logic                      r_s1_first;
  logic                      r_s1_last;
  logic signed [SUM_W-1:0]   r_sum;
  logic signed [BIAS_W-1:0]  r_bias;

  logic signed [ACC_W-1:0]   r_acc;
  logic                      r_sat;

  logic signed [PROD_W-1:0]  w_prod [N_LANES];
  logic signed [SUM_W-1:0]   w_sum;
  logic                      w_accept;
  logic                      w_handshake;
  logic signed [EXT_W-1:0]   w_acc_ext;
  logic signed [ACC_W-1:0]   w_acc_new;
  logic                      w_acc_clamp;
  logic signed [EXT_W-1:0]   w_pre_ext;
  logic signed [ACC_W-1:0]   w_pre;
  logic                      w_bias_clamp;
  logic signed [ACC_W-1:0]   w_shift;
  logic signed [EXT_W-1:0]   w_act_ext;
  logic [OUT_W-1:0]          w_act;
  logic                      w_sat_new;

  function automatic logic signed [ACC_W-1:0] f_sat(input logic signed [EXT_W-1:0] v);
    if (v > ACC_MAX)      return ACC_MAX[ACC_W-1:0];
    else if (v < ACC_MIN) return ACC_MIN[ACC_W-1:0];
    else                  return v[ACC_W-1:0];
  endfunction

  function automatic logic f_ovf(input logic signed [EXT_W-1:0] v);
    return (v > ACC_MAX) || (v < ACC_MIN);
  endfunction

  // Inputs are unsigned activations: a zero MSB makes the signed product correct.
  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
    assign w_prod[gi] = PROD_W'($signed(bus.weights[gi*W_W +: W_W]))
                      * PROD_W'($signed({1'b0, bus.inputs[gi*IN_W +: IN_W]}));
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N_LANES; i++) begin
      w_sum = w_sum + SUM_W'(w_prod[i]);
    end
  end

  assign w_accept    = bus.in_valid && r_in_ready;
  assign w_handshake = r_out_valid && bus.out_ready;

  // A first beat restarts from the sum alone; SUM_W <= ACC_W so it cannot clamp.
  assign w_acc_ext    = EXT_W'(r_acc) + EXT_W'(r_sum);
  assign w_acc_new    = r_s1_first ? ACC_W'(r_sum) : f_sat(w_acc_ext);
  assign w_acc_clamp  = !r_s1_first && f_ovf(w_acc_ext);
  assign w_pre_ext    = EXT_W'(w_acc_new) + EXT_W'(r_bias);
  assign w_pre        = f_sat(w_pre_ext);
  assign w_bias_clamp = f_ovf(w_pre_ext);
  assign w_shift      = w_pre >>> FRAC;
  assign w_act_ext    = EXT_W'(w_shift) + ACT_OFFSET;
  assign w_act        = w_act_ext[EXT_W-1]     ? '0 :
                        (w_act_ext > OUT_MAX)  ? OUT_MAX[OUT_W-1:0] :
                                                 w_act_ext[OUT_W-1:0];
  assign w_sat_new    = (r_s1_first ? 1'b0 : r_sat) | w_acc_clamp | (r_s1_last & w_bias_clamp);

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sat   = r_out_sat;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_sum      <= '0;
      r_bias     <= '0;
      r_acc      <= '0;
      r_sat      <= 1'b0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
      r_res_done <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_sum      <= w_sum;
        r_s1_first <= bus.first;
        r_s1_last  <= bus.last;
        r_bias     <= bus.bias;
      end
      r_res_done <= r_s1_valid && r_s1_last;
      if (r_s1_valid) begin
        r_acc <= w_acc_new;
        r_sat <= w_sat_new;
        if (r_s1_last) begin
          r_out_data <= w_act;
          r_out_sat  <= w_sat_new;
        end
      end
      if (w_handshake) begin
        r_acc <= '0;
        r_sat <= 1'b0;
      end
    end
  end

  // Result registers are written one cycle before OUT, so out_valid lags the last beat by two edges.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= S_ACC;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_ACC: begin
          r_in_ready <= 1'b1;
          if (w_accept && bus.last) begin
            r_state    <= S_DRAIN;
            r_in_ready <= 1'b0;
          end
        end
        S_DRAIN: begin
          r_in_ready <= 1'b0;
          if (r_res_done) begin
            r_state     <= S_OUT;
            r_out_valid <= 1'b1;
          end
        end
        S_OUT: begin
          if (w_handshake) begin
            r_state     <= S_ACC;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_ACC;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
